// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_if: bundle between the ID stage (driver of *_i) and the ID/EX pipeline
// register (driver of *_o).
//   master : ID side / testbench. Drives freeze/flush/valid, control bits,
//            operands and specifiers. Observes registered EX-stage values,
//            stall_o and bubble_cnt_o.
//   slave  : id_ex_stage. Consumes *_i and produces *_o.
// -----------------------------------------------------------------------------
interface id_ex_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    // ID-stage side
    logic              freeze_i;
    logic              flush_i;
    logic              id_valid_i;
    logic              RegDst_i;
    logic              ALUSrc_i;
    logic              MemRead_i;
    logic              MemWrite_i;
    logic              RegWrite_i;
    logic              MemToReg_i;
    logic [1:0]        ALUOp_i;
    logic [DATA_W-1:0] data1_i;
    logic [DATA_W-1:0] data2_i;
    logic [DATA_W-1:0] imm_i;
    logic [REG_W-1:0]  rs_i;
    logic [REG_W-1:0]  rt_i;
    logic [REG_W-1:0]  rd_i;

    // EX-stage side
    logic              RegDst_o;
    logic              ALUSrc_o;
    logic              MemRead_o;
    logic              MemWrite_o;
    logic              RegWrite_o;
    logic              MemToReg_o;
    logic [1:0]        ALUOp_o;
    logic [DATA_W-1:0] data1_o;
    logic [DATA_W-1:0] data2_o;
    logic [DATA_W-1:0] imm_o;
    logic [REG_W-1:0]  rs_o;
    logic [REG_W-1:0]  rt_o;
    logic [REG_W-1:0]  rd_o;
    logic              valid_o;
    logic              stall_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output freeze_i, flush_i, id_valid_i,
        output RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i,
        output ALUOp_i, data1_i, data2_i, imm_i, rs_i, rt_i, rd_i,
        input  RegDst_o, ALUSrc_o, MemRead_o, MemWrite_o, RegWrite_o, MemToReg_o,
        input  ALUOp_o, data1_o, data2_o, imm_o, rs_o, rt_o, rd_o,
        input  valid_o, stall_o, bubble_cnt_o
    );

    modport slave (
        input  freeze_i, flush_i, id_valid_i,
        input  RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i,
        input  ALUOp_i, data1_i, data2_i, imm_i, rs_i, rt_i, rd_i,
        output RegDst_o, ALUSrc_o, MemRead_o, MemWrite_o, RegWrite_o, MemToReg_o,
        output ALUOp_o, data1_o, data2_o, imm_o, rs_o, rt_o, rd_o,
        output valid_o, stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage: ID/EX pipeline register of the 5-stage MIPS core.
//   clk_i : clock, all state updates on the rising edge
//   rst_i : synchronous active-high reset
//   bus   : id_ex_if.slave
//           in : freeze_i, flush_i, id_valid_i, control bits, ALUOp_i,
//                data1_i/data2_i/imm_i, rs_i/rt_i/rd_i
//           out: registered control/data/specifiers, valid_o,
//                stall_o (load-use hazard, combinational),
//                bubble_cnt_o (saturating count of flush/stall bubbles)
// Edge priority: reset > freeze (hold all) > bubble (load zeros) > load.
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic   clk_i,
    input  logic   rst_i,
    id_ex_if.slave bus
);

    typedef struct packed {
        logic              reg_dst;
        logic              alu_src;
        logic              mem_read;
        logic              mem_write;
        logic              reg_write;
        logic              mem_to_reg;
        logic [1:0]        alu_op;
        logic [DATA_W-1:0] data1;
        logic [DATA_W-1:0] data2;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic              valid;
    } ex_t;

    ex_t              ex_q, ex_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             stall;
    logic             counted;
    logic             bubble;

    // Load in EX whose destination (rt) is read by the instruction in ID.
    // Both rs and rt are compared for every instruction type on purpose;
    // a write to r0 never creates a dependency.
    always_comb begin
        stall = ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) && bus.id_valid_i &&
                ((ex_q.rt == bus.rs_i) || (ex_q.rt == bus.rt_i));
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        ex_d         = ex_q;
        bubble_cnt_d = bubble_cnt_q;
        counted      = bus.flush_i || stall;
        bubble       = counted || !bus.id_valid_i;

        if (!bus.freeze_i) begin
            if (bubble) begin
                ex_d = '0;
                // Idle slots (no valid instruction in ID) are not counted.
                if (counted && (bubble_cnt_q != '1)) begin
                    bubble_cnt_d = bubble_cnt_q + 1'b1;
                end
            end else begin
                ex_d.reg_dst    = bus.RegDst_i;
                ex_d.alu_src    = bus.ALUSrc_i;
                ex_d.mem_read   = bus.MemRead_i;
                ex_d.mem_write  = bus.MemWrite_i;
                ex_d.reg_write  = bus.RegWrite_i;
                ex_d.mem_to_reg = bus.MemToReg_i;
                ex_d.alu_op     = bus.ALUOp_i;
                ex_d.data1      = bus.data1_i;
                ex_d.data2      = bus.data2_i;
                ex_d.imm        = bus.imm_i;
                ex_d.rs         = bus.rs_i;
                ex_d.rt         = bus.rt_i;
                ex_d.rd         = bus.rd_i;
                ex_d.valid      = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i) begin
        // NOTE: data fields are cleared along with control so a reset bubble
        // presents all-zero outputs, not stale operands.
        if (rst_i) begin
            ex_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bus.RegDst_o     = ex_q.reg_dst;
    assign bus.ALUSrc_o     = ex_q.alu_src;
    assign bus.MemRead_o    = ex_q.mem_read;
    assign bus.MemWrite_o   = ex_q.mem_write;
    assign bus.RegWrite_o   = ex_q.reg_write;
    assign bus.MemToReg_o   = ex_q.mem_to_reg;
    assign bus.ALUOp_o      = ex_q.alu_op;
    assign bus.data1_o      = ex_q.data1;
    assign bus.data2_o      = ex_q.data2;
    assign bus.imm_o        = ex_q.imm;
    assign bus.rs_o         = ex_q.rs;
    assign bus.rt_o         = ex_q.rt;
    assign bus.rd_o         = ex_q.rd;
    assign bus.valid_o      = ex_q.valid;
    assign bus.stall_o      = stall;
    assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage: directed vector table, randomized run against a reference
// model of the ID/EX register, and a counter saturation sequence.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Instruction as seen in ID; field order matches the packed output view.
    typedef struct packed {
        logic        reg_dst;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic [1:0]  alu_op;
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } instr_t;

    typedef struct {
        string       name;
        instr_t      id;
        bit          idv;
        bit          fl;
        bit          fr;
        bit          rst;
        bit          chk_stall;
        logic        exp_stall;
        logic [7:0]  exp_ctrl;
        logic [4:0]  exp_rd;
        logic        exp_valid;
        logic [15:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_ex_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the instruction currently in EX and the bubble tally.
    instr_t m_ex    = '0;
    bit     m_valid = 1'b0;
    int     m_cnt   = 0;

    vec_t vecs[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic [7:0] ctrl, input logic [4:0] rs,
                                  input logic [4:0] rt, input logic [4:0] rd);
        instr_t i;
        {i.reg_dst, i.alu_src, i.mem_read, i.mem_write, i.reg_write, i.mem_to_reg, i.alu_op} = ctrl;
        i.rs    = rs;
        i.rt    = rt;
        i.rd    = rd;
        i.data1 = 32'hA000_0000 + 32'(rs) * 32'h101;
        i.data2 = 32'hB000_0000 + 32'(rt) * 32'h202;
        i.imm   = 32'hFFFF_FF00 | 32'(rd);
        return i;
    endfunction

    function automatic logic [127:0] dut_view();
        return 128'({bus.RegDst_o, bus.ALUSrc_o, bus.MemRead_o, bus.MemWrite_o,
                     bus.RegWrite_o, bus.MemToReg_o, bus.ALUOp_o,
                     bus.data1_o, bus.data2_o, bus.imm_o,
                     bus.rs_o, bus.rt_o, bus.rd_o, bus.valid_o});
    endfunction

    function automatic logic [7:0] dut_ctrl();
        return {bus.RegDst_o, bus.ALUSrc_o, bus.MemRead_o, bus.MemWrite_o,
                bus.RegWrite_o, bus.MemToReg_o, bus.ALUOp_o};
    endfunction

    // Hazard: the EX instruction is a load writing a nonzero register that
    // the valid ID instruction names in either source field.
    function automatic bit model_stall(input instr_t id, input bit idv);
        return m_valid && m_ex.mem_read && (m_ex.rt != 0) && idv &&
               ((m_ex.rt == id.rs) || (m_ex.rt == id.rt));
    endfunction

    task automatic drive(input instr_t id, input bit idv, input bit fl, input bit fr, input bit r);
        rst            = r;
        bus.freeze_i   = fr;
        bus.flush_i    = fl;
        bus.id_valid_i = idv;
        bus.RegDst_i   = id.reg_dst;
        bus.ALUSrc_i   = id.alu_src;
        bus.MemRead_i  = id.mem_read;
        bus.MemWrite_i = id.mem_write;
        bus.RegWrite_i = id.reg_write;
        bus.MemToReg_i = id.mem_to_reg;
        bus.ALUOp_i    = id.alu_op;
        bus.data1_i    = id.data1;
        bus.data2_i    = id.data2;
        bus.imm_i      = id.imm;
        bus.rs_i       = id.rs;
        bus.rt_i       = id.rt;
        bus.rd_i       = id.rd;
    endtask

    // One cycle: drive, check stall against the model, advance the model,
    // clock, then compare the registered outputs and counter with the model.
    task automatic apply(input string name, input instr_t id, input bit idv, input bit fl,
                         input bit fr, input bit r, input bit chk_stall);
        bit hz;
        drive(id, idv, fl, fr, r);
        #1;
        hz = model_stall(id, idv);
        if (chk_stall) check({name, " stall(model)"}, 128'(bus.stall_o), 128'(hz));
        if (r) begin
            m_ex = '0; m_valid = 1'b0; m_cnt = 0;
        end else if (!fr) begin
            if (fl || hz || !idv) begin
                m_ex    = '0;
                m_valid = 1'b0;
                if ((fl || hz) && m_cnt < CNT_MAX) m_cnt++;
            end else begin
                m_ex    = id;
                m_valid = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check({name, " outputs(model)"}, dut_view(), 128'({m_ex, m_valid}));
        check({name, " count(model)"}, 128'(bus.bubble_cnt_o), 128'(m_cnt));
    endtask

    task automatic add_vec(input string name, input instr_t id, input bit idv, input bit fl,
                           input bit fr, input bit r, input bit chk_stall, input logic exp_stall,
                           input logic [7:0] exp_ctrl, input logic [4:0] exp_rd,
                           input logic exp_valid, input logic [15:0] exp_cnt);
        vec_t v;
        v.name = name; v.id = id; v.idv = idv; v.fl = fl; v.fr = fr; v.rst = r;
        v.chk_stall = chk_stall; v.exp_stall = exp_stall; v.exp_ctrl = exp_ctrl;
        v.exp_rd = exp_rd; v.exp_valid = exp_valid; v.exp_cnt = exp_cnt;
        vecs.push_back(v);
    endtask

    // Control byte: {RegDst, ALUSrc, MemRead, MemWrite, RegWrite, MemToReg, ALUOp}
    localparam logic [7:0] C_ADD  = 8'h89;
    localparam logic [7:0] C_LW   = 8'h6C;
    localparam logic [7:0] C_ADDI = 8'h48;
    localparam logic [7:0] C_SW   = 8'h50;

    initial begin
        instr_t all_ones;
        instr_t ri;
        all_ones = '1;
        drive('0, 1'b0, 1'b0, 1'b0, 1'b0);

        //       name            id                         idv fl fr rst chk stall ctrl    rd  vld cnt
        add_vec("rst0",        all_ones,                   1, 1, 1, 1,  0, 0,   8'h00, 0,  0, 0);
        add_vec("rst1",        all_ones,                   1, 1, 1, 1,  1, 0,   8'h00, 0,  0, 0);
        add_vec("add_r3",      mk(C_ADD, 1, 2, 3),         1, 0, 0, 0,  1, 0,   C_ADD, 3,  1, 0);
        add_vec("lw_r5",       mk(C_LW, 1, 5, 0),          1, 0, 0, 0,  1, 0,   C_LW,  0,  1, 0);
        add_vec("use_r5_stall",mk(C_ADD, 5, 2, 6),         1, 0, 0, 0,  1, 1,   8'h00, 0,  0, 1);
        add_vec("use_r5_enter",mk(C_ADD, 5, 2, 6),         1, 0, 0, 0,  1, 0,   C_ADD, 6,  1, 1);
        add_vec("lw_r0",       mk(C_LW, 1, 0, 0),          1, 0, 0, 0,  1, 0,   C_LW,  0,  1, 1);
        add_vec("use_r0",      mk(C_ADD, 0, 0, 7),         1, 0, 0, 0,  1, 0,   C_ADD, 7,  1, 1);
        add_vec("addi_r5",     mk(C_ADDI, 1, 5, 0),        1, 0, 0, 0,  1, 0,   C_ADDI,0,  1, 1);
        add_vec("nonload_use", mk(C_ADD, 5, 2, 8),         1, 0, 0, 0,  1, 0,   C_ADD, 8,  1, 1);
        add_vec("flush_sw",    mk(C_SW, 1, 9, 0),          1, 1, 0, 0,  1, 0,   8'h00, 0,  0, 2);
        add_vec("lw_r5_b",     mk(C_LW, 1, 5, 0),          1, 0, 0, 0,  1, 0,   C_LW,  0,  1, 2);
        add_vec("flush_stall", mk(C_ADD, 2, 5, 10),        1, 1, 0, 0,  1, 1,   8'h00, 0,  0, 3);
        add_vec("lw_r5_c",     mk(C_LW, 1, 5, 0),          1, 0, 0, 0,  1, 0,   C_LW,  0,  1, 3);
        add_vec("freeze1",     mk(C_ADD, 5, 5, 11),        1, 0, 1, 0,  1, 1,   C_LW,  0,  1, 3);
        add_vec("freeze2",     mk(C_ADD, 5, 5, 11),        1, 0, 1, 0,  1, 1,   C_LW,  0,  1, 3);
        add_vec("freeze3",     mk(C_ADD, 5, 5, 11),        1, 0, 1, 0,  1, 1,   C_LW,  0,  1, 3);
        add_vec("unfreeze",    mk(C_ADD, 5, 5, 11),        1, 0, 0, 0,  1, 1,   8'h00, 0,  0, 4);
        add_vec("dep_enters",  mk(C_ADD, 5, 5, 11),        1, 0, 0, 0,  1, 0,   C_ADD, 11, 1, 4);
        add_vec("idle",        mk(C_ADD, 1, 2, 12),        0, 0, 0, 0,  1, 0,   8'h00, 0,  0, 4);
        add_vec("lw_r5_d",     mk(C_LW, 1, 5, 0),          1, 0, 0, 0,  1, 0,   C_LW,  0,  1, 4);
        add_vec("rst_mid",     mk(C_ADD, 5, 2, 13),        1, 0, 0, 1,  1, 1,   8'h00, 0,  0, 0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.id, v.idv, v.fl, v.fr, v.rst);
            #1;
            if (v.chk_stall) check({v.name, " stall"}, 128'(bus.stall_o), 128'(v.exp_stall));
            #1;
            apply(v.name, v.id, v.idv, v.fl, v.fr, v.rst, 1'b0);
            check({v.name, " ctrl"},  128'(dut_ctrl()),         128'(v.exp_ctrl));
            check({v.name, " rd"},    128'(bus.rd_o),           128'(v.exp_rd));
            check({v.name, " valid"}, 128'(bus.valid_o),        128'(v.exp_valid));
            check({v.name, " count"}, 128'(bus.bubble_cnt_o),   128'(v.exp_cnt));
        end

        // Randomized traffic with a small register range to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            ri       = '0;
            {ri.reg_dst, ri.alu_src, ri.mem_write, ri.reg_write, ri.mem_to_reg} = 5'($urandom);
            ri.alu_op   = 2'($urandom);
            ri.mem_read = ($urandom_range(0, 2) == 0);
            ri.data1    = $urandom;
            ri.data2    = $urandom;
            ri.imm      = $urandom;
            ri.rs       = 5'($urandom_range(0, 7));
            ri.rt       = 5'($urandom_range(0, 7));
            ri.rd       = 5'($urandom);
            apply("rand", ri,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 99) == 0,
                  1'b1);
        end

        // Saturation: a long run of flushes pins the counter at all-ones.
        apply("sat_rst", mk(C_ADD, 1, 2, 3), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(mk(C_SW, 1, 2, 0), 1'b1, 1'b1, 1'b0, 1'b0);
        for (int n = 0; n < CNT_MAX - 1; n++) @(posedge clk);
        #1;
        check("sat below max", 128'(bus.bubble_cnt_o), 128'(16'hFFFE));
        @(posedge clk);
        #1;
        check("sat at max", 128'(bus.bubble_cnt_o), 128'(16'hFFFF));
        for (int n = 0; n < 6; n++) @(posedge clk);
        #1;
        check("sat held", 128'(bus.bubble_cnt_o), 128'(16'hFFFF));
        check("sat valid", 128'(bus.valid_o), 128'(1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("sat reset count", 128'(bus.bubble_cnt_o), 128'(16'h0000));
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage MIPS core. It consumes the decoded control bits from the ID-stage control unit, plus register-file read data, the sign-extended immediate and the register specifiers.
- Presents all of these registered to the EX/MEM/WB stages.
- Owns load-use hazard detection: inserts a bubble and tells PC/IF-ID to hold.
- Handles flush on taken branch/jump, a global freeze, and keeps a saturating bubble counter for performance measurement.

Parameters:
DATA_W, 32, width of data1/data2/imm fields
REG_W, 5, width of register specifiers
CNT_W, 16, width of bubble counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous active-high reset
freeze_i  in  1  global hold (e.g. memory stall); register keeps contents
flush_i  in  1  taken branch/jump in ID; the instruction in ID must not enter EX
id_valid_i  in  1  ID holds a real instruction
RegDst_i, ALUSrc_i, MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i  in  1 each  control bits from control unit
ALUOp_i  in  2  ALU op class
data1_i, data2_i  in  DATA_W  rs/rt read data
imm_i  in  DATA_W  sign-extended immediate (funct in [5:0])
rs_i, rt_i, rd_i  in  REG_W  ID-stage specifiers
RegDst_o, ALUSrc_o, MemRead_o, MemWrite_o, RegWrite_o, MemToReg_o  out  1 each  registered control
ALUOp_o  out  2  registered ALU op class
data1_o, data2_o, imm_o  out  DATA_W  registered data
rs_o, rt_o, rd_o  out  REG_W  registered specifiers (feed forwarding unit)
valid_o  out  1  EX stage holds a real instruction
stall_o  out  1  load-use hazard, combinational; PC and IF/ID must hold
bubble_cnt_o  out  CNT_W  number of bubbles inserted since reset

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous and active-high.
- Reset: all registered outputs 0 (control bits, ALUOp, data, specifiers, valid_o, bubble_cnt_o). A reset mid-operation discards the EX instruction; the first post-reset cycle is a bubble.
- stall_o = valid_o & MemRead_o & (rt_o != 0) & id_valid_i & ((rt_o == rs_i) | (rt_o == rt_i)).
  - Compare both rs and rt regardless of instruction type; this is a deliberate conservative choice.
  - stall_o is purely a function of current register state and ID inputs. It has no dependency on freeze_i or flush_i.
- Per-edge update priority:
  1. rst_i: clear everything.
  2. freeze_i: hold every register, including the counter. stall_o stays asserted, so the hazard persists.
  3. bubble = flush_i | stall_o | ~id_valid_i: all control bits, ALUOp, data, specifiers and valid_o load 0.
  4. Otherwise load all inputs unchanged; valid_o <= 1.
- Counter: increments by 1 on each edge where case 3 applies and (flush_i | stall_o) is true. It saturates at all-ones with no wrap. Idle bubbles from ~id_valid_i are not counted.
- Latency: inputs appear on outputs exactly 1 cycle after capture.
- Load-use stall lasts exactly one cycle per hazard. After the bubble, MemRead_o = 0, so stall_o drops and the held ID instruction enters on the next edge.
- flush_i and stall_o together: one bubble, counter +1 (not +2).
- A bubble must not write regs or memory downstream: RegWrite_o = MemWrite_o = MemRead_o = 0.

Test Plan:
- Reset: hold rst_i 2 cycles with all inputs at 1 -> every output 0, bubble_cnt_o = 0; then pass add r3,r1,r2 (RegDst=1, RegWrite=1, ALUOp=2'b01) -> same values out 1 cycle later, valid_o = 1.
- Load-use: lw r5 (MemRead=1, RegWrite=1, MemToReg=1, rt=5) followed by add rs=5 -> stall_o = 1 for exactly 1 cycle, then control outputs 0 for 1 cycle, then the add appears; bubble_cnt_o = 1.
- No false stall: lw into rt=0 followed by a use of r0 -> stall_o = 0. A non-load (MemRead=0) with rt=5 followed by rs=5 -> stall_o = 0.
- Flush: assert flush_i with a valid sw (MemWrite=1) in ID -> next cycle MemWrite_o = 0, valid_o = 0, counter +1. Assert flush_i and stall_o together -> counter +1 only.
- Freeze: with an lw in EX and a dependent instruction in ID, hold freeze_i for 3 cycles -> outputs unchanged, stall_o = 1 throughout, counter unchanged. Release -> one bubble, then the dependent instruction enters.
- Saturation: force 2^CNT_W + 5 flushes -> bubble_cnt_o = 16'hFFFF. Assert rst_i mid-stream -> 0 on the next edge.
